// File: rtl/icache_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// icache_mem_ctrl_pkg
// Shared definitions for the instruction-cache miss/prefetch controller:
// memory bus command encodings and the MSHR entry record.
// ----------------------------------------------------------------------------
package icache_mem_ctrl_pkg;

   // Memory bus commands (sys_defs encoding)
   localparam logic [1:0] BUS_NONE  = 2'h0;
   localparam logic [1:0] BUS_LOAD  = 2'h1;
   localparam logic [1:0] BUS_STORE = 2'h2;

   localparam int unsigned LineW = 61;

   // Invalid: free slot; Pending: line known, request not yet accepted;
   // Waiting: accepted by the arbiter, memory tag held until the data returns.
   typedef enum logic [1:0] {
      Invalid,
      Pending,
      Waiting
   } mshr_state_e;

   typedef struct packed {
      mshr_state_e      state;
      logic [LineW-1:0] line;
      logic [3:0]       tag;
      logic             demand;
   } mshr_entry_t;

endpackage

// File: rtl/icache_mem_ctrl_pick.sv
// ----------------------------------------------------------------------------
// icache_mem_ctrl_pick
// Priority encoder returning the lowest-index set bit of a request vector.
// Ports:
//   req   - request vector, one bit per MSHR entry
//   found - at least one bit of req is set
//   idx   - index of the lowest set bit (0 when found is low)
// ----------------------------------------------------------------------------
module icache_mem_ctrl_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = 2
) (
   input  logic [N-1:0]    req,
   output logic            found,
   output logic [IdxW-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/icache_mem_ctrl.sv
// ----------------------------------------------------------------------------
// icache_mem_ctrl
// Miss/prefetch controller between the Icache and the arbiter's Icache port.
// Each miss allocates the demand line plus PREFETCH_LINES-1 sequential lines
// into a small MSHR file, issues them as BUS_LOAD (demand lines first), holds
// the memory tag once accepted and turns matching returns into fill writes.
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   proc2Icache_addr        - missing fetch address (line = addr[63:3])
//   miss_valid              - lookup missed this cycle
//   Icache_response_in      - arbiter accept tag (0 = not accepted, retry)
//   Icache_tag_in/data_in   - returning memory tag and its data
//   Icache_addr_out/command - request to the arbiter
//   fill_en/addr/data       - one-line write into the Icache arrays
//   mshr_full               - no free MSHR entry
// ----------------------------------------------------------------------------
module icache_mem_ctrl
   import icache_mem_ctrl_pkg::*;
#(
   parameter int unsigned NUM_MSHR       = 4,
   parameter int unsigned PREFETCH_LINES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] proc2Icache_addr,
   input  logic        miss_valid,
   input  logic [3:0]  Icache_response_in,
   input  logic [3:0]  Icache_tag_in,
   input  logic [63:0] Icache_data_in,
   output logic [63:0] Icache_addr_out,
   output logic [1:0]  Icache_command_out,
   output logic        fill_en,
   output logic [63:0] fill_addr,
   output logic [63:0] fill_data,
   output logic        mshr_full
);

   localparam int unsigned IdxW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

   mshr_entry_t      entries_q [NUM_MSHR];
   mshr_entry_t      entries_d [NUM_MSHR];
   logic [LineW-1:0] last_line_q;
   logic             last_valid_q;

   logic [LineW-1:0]    miss_line;
   logic [2:0]          unused_addr_bits;
   logic                redirect;
   logic [NUM_MSHR-1:0] pend_vec, dem_vec, ret_vec, free_vec;
   logic                dem_found, any_found, ret_found;
   logic [IdxW-1:0]     dem_idx, any_idx, ret_idx, issue_idx;
   logic                issue_valid, accept;

   // Allocation scratch
   logic [NUM_MSHR-1:0] live_vec, avail_vec;
   logic [LineW-1:0]    cand;
   logic                dup, slot_found;
   logic [IdxW-1:0]     slot;

   assign miss_line        = proc2Icache_addr[63:3];
   assign unused_addr_bits = proc2Icache_addr[2:0];
   assign redirect         = miss_valid & (~last_valid_q | (miss_line != last_line_q));

   always_comb begin
      pend_vec = '0;
      dem_vec  = '0;
      ret_vec  = '0;
      free_vec = '0;
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
         pend_vec[i] = (entries_q[i].state == Pending);
         dem_vec[i]  = (entries_q[i].state == Pending) & entries_q[i].demand;
         ret_vec[i]  = (entries_q[i].state == Waiting) && (Icache_tag_in != 4'd0) &&
                       (entries_q[i].tag == Icache_tag_in);
         free_vec[i] = (entries_q[i].state == Invalid);
      end
   end

   icache_mem_ctrl_pick #(.N(NUM_MSHR), .IdxW(IdxW)) u_pick_dem (
      .req   (dem_vec),
      .found (dem_found),
      .idx   (dem_idx)
   );

   icache_mem_ctrl_pick #(.N(NUM_MSHR), .IdxW(IdxW)) u_pick_any (
      .req   (pend_vec),
      .found (any_found),
      .idx   (any_idx)
   );

   icache_mem_ctrl_pick #(.N(NUM_MSHR), .IdxW(IdxW)) u_pick_ret (
      .req   (ret_vec),
      .found (ret_found),
      .idx   (ret_idx)
   );

   // A redirect squashes every Pending entry at this edge, so nothing is
   // offered to the arbiter in that cycle (an accept would orphan the tag).
   assign issue_valid = any_found & ~redirect;
   assign issue_idx   = dem_found ? dem_idx : any_idx;
   assign accept      = issue_valid & (Icache_response_in != 4'd0);

   always_comb begin
      Icache_command_out = BUS_NONE;
      Icache_addr_out    = '0;
      if (issue_valid) begin
         Icache_command_out = BUS_LOAD;
         Icache_addr_out    = {entries_q[issue_idx].line, 3'b000};
      end
   end

   always_comb begin
      fill_en   = ret_found;
      fill_addr = '0;
      fill_data = '0;
      if (ret_found) begin
         fill_addr = {entries_q[ret_idx].line, 3'b000};
         fill_data = Icache_data_in;
      end
   end

   assign mshr_full = ~|free_vec;

   always_comb begin
      entries_d  = entries_q;
      live_vec   = '0;
      avail_vec  = '0;
      cand       = '0;
      dup        = 1'b0;
      slot_found = 1'b0;
      slot       = '0;

      if (ret_found) begin
         entries_d[ret_idx].state = Invalid;
      end
      if (accept) begin
         entries_d[issue_idx].state = Waiting;
         entries_d[issue_idx].tag   = Icache_response_in;
      end

      // Lines still tracked after the squash, and slots usable this edge.
      // A slot freed by a return this cycle is deliberately not reusable.
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
         live_vec[i]  = (entries_q[i].state == Waiting) |
                        ((entries_q[i].state == Pending) & ~redirect);
         avail_vec[i] = (entries_q[i].state == Invalid) |
                        ((entries_q[i].state == Pending) & redirect);
         if (redirect && (entries_q[i].state == Pending)) begin
            entries_d[i].state = Invalid;
         end
      end

      if (miss_valid) begin
         for (int unsigned k = 0; k < PREFETCH_LINES; k++) begin
            cand = miss_line + LineW'(k);
            dup  = 1'b0;
            for (int unsigned i = 0; i < NUM_MSHR; i++) begin
               if (live_vec[i] && (entries_q[i].line == cand)) begin
                  dup = 1'b1;
               end
            end
            slot_found = 1'b0;
            slot       = '0;
            for (int i = int'(NUM_MSHR) - 1; i >= 0; i--) begin
               if (avail_vec[i]) begin
                  slot_found = 1'b1;
                  slot       = IdxW'(i);
               end
            end
            if (!dup && slot_found) begin
               entries_d[slot].state  = Pending;
               entries_d[slot].line   = cand;
               entries_d[slot].tag    = 4'd0;
               entries_d[slot].demand = (k == 0);
               avail_vec[slot]        = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            entries_q[i] <= '{state: Invalid, line: '0, tag: 4'd0, demand: 1'b0};
         end
         last_line_q  <= '0;
         last_valid_q <= 1'b0;
      end else begin
         entries_q <= entries_d;
         if (miss_valid) begin
            last_line_q  <= miss_line;
            last_valid_q <= 1'b1;
         end
      end
   end

endmodule
